// File: rtl/pdf_header_checker.sv
// pdf_header_checker
//   Consumes a byte stream over a valid/ready handshake and checks it against
//   the PDF signature "%PDF-1." followed by one ASCII version digit ('0'..'9').
//   Reports pass/fail, the captured version digit, the index of the first bad
//   byte, or an abort when the source stalls for TIMEOUT busy cycles.
//
// Parameters
//   SIG_LEN  signature length in bytes (7 for "%PDF-1."; must be <= 15)
//   TIMEOUT  busy cycles without an accepted byte before the check aborts (>= 2)
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     one-cycle pulse, starts a check from IDLE or DONE
//   in_valid  source presents in_data
//   in_data   byte from the source
//   in_ready  checker accepts a byte this cycle (registered copy of busy)
//   busy      check in progress
//   done      result valid, held until the next start or rst
//   match     full signature plus valid digit received
//   timeout   check aborted by the idle counter
//   version   accepted version byte (valid when match)
//   err_pos   index of the first mismatching byte (valid when done & !match & !timeout)
module pdf_header_checker #(
  parameter int SIG_LEN = 7,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       busy,
  output logic       done,
  output logic       match,
  output logic       timeout,
  output logic [7:0] version,
  output logic [3:0] err_pos
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0]       IDX_LAST = 4'(SIG_LEN - 1);
  localparam logic [3:0]       IDX_VER  = 4'(SIG_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MATCH = 2'd1,
    VER   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       idx, idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             match_nxt, timeout_nxt;
  logic [7:0]       version_nxt;
  logic [3:0]       err_nxt;
  logic             busy_nxt, done_nxt;
  logic             accept;

  // Expected signature byte at a given index: "%PDF-1."
  function automatic logic [7:0] sig_at(input logic [3:0] i);
    case (i)
      4'd0:    sig_at = 8'h25;
      4'd1:    sig_at = 8'h50;
      4'd2:    sig_at = 8'h44;
      4'd3:    sig_at = 8'h46;
      4'd4:    sig_at = 8'h2D;
      4'd5:    sig_at = 8'h31;
      4'd6:    sig_at = 8'h2E;
      default: sig_at = 8'h00;
    endcase
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    is_digit = (b >= 8'h30) && (b <= 8'h39);
  endfunction

  // in_ready is the registered busy flag, so accept never feeds back into ready.
  assign accept = in_ready && in_valid;

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    cnt_nxt     = cnt;
    match_nxt   = match;
    timeout_nxt = timeout;
    version_nxt = version;
    err_nxt     = err_pos;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt   = MATCH;
          idx_nxt     = '0;
          cnt_nxt     = '0;
          match_nxt   = 1'b0;
          timeout_nxt = 1'b0;
          version_nxt = '0;
          err_nxt     = '0;
        end
      end
      MATCH, VER: begin
        // An accepted byte wins over an expiring idle counter on the same edge.
        if (accept) begin
          cnt_nxt = '0;
          if (state == MATCH) begin
            if (in_data == sig_at(idx)) begin
              idx_nxt = idx + 4'd1;
              if (idx == IDX_LAST) state_nxt = VER;
            end else begin
              err_nxt   = idx;
              state_nxt = DONE;
            end
          end else begin
            if (is_digit(in_data)) begin
              version_nxt = in_data;
              match_nxt   = 1'b1;
            end else begin
              err_nxt = IDX_VER;
            end
            state_nxt = DONE;
          end
        end else if (cnt == CNT_TOP) begin
          timeout_nxt = 1'b1;
          match_nxt   = 1'b0;
          state_nxt   = DONE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == MATCH) || (state_nxt == VER);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      in_ready <= 1'b0;
      done     <= 1'b0;
      match    <= 1'b0;
      timeout  <= 1'b0;
      version  <= '0;
      err_pos  <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      cnt      <= cnt_nxt;
      busy     <= busy_nxt;
      in_ready <= busy_nxt;
      done     <= done_nxt;
      match    <= match_nxt;
      timeout  <= timeout_nxt;
      version  <= version_nxt;
      err_pos  <= err_nxt;
    end
  end

endmodule
